// File: rtl/vga_timing_engine.sv
// Parametrised VGA raster engine: h/v counters, sync and blanking, plus a client
// colour path whose latency is matched by a PIPE-stage delay line on sync/blank.
module vga_timing_engine #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned PIPE     = 1,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_req,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_cnt,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic [COLOR_W-1:0] vga_R,
    output logic [COLOR_W-1:0] vga_G,
    output logic [COLOR_W-1:0] vga_B
);

    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DW-1:0]      div_q;
    logic [XW-1:0]      hCnt_q;
    logic [YW-1:0]      vCnt_q;
    logic [15:0]        frameCnt_q;
    logic               hSync_q;
    logic               vSync_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;

    logic        tick;
    logic [31:0] hWide;
    logic [31:0] vWide;
    logic        hLast;
    logic        vLast;
    logic [2:0]  stage0;
    logic [2:0]  dlyOut;

    // Reset is folded into tick so the strobes drop the moment reset asserts.
    assign tick   = en && reset && (div_q == '0);
    assign hWide  = 32'(hCnt_q);
    assign vWide  = 32'(vCnt_q);
    assign hLast  = (hWide == H_TOTAL - 1);
    assign vLast  = (vWide == V_TOTAL - 1);
    assign stage0 = {(hWide < H_ACTIVE) && (vWide < V_ACTIVE),
                     (hWide >= HS_START) && (hWide < HS_END),
                     (vWide >= VS_START) && (vWide < VS_END)};

    assign pix_x       = hCnt_q;
    assign pix_y       = vCnt_q;
    assign pix_req     = tick && stage0[2];
    assign line_start  = tick && (hCnt_q == '0);
    assign frame_start = tick && (hCnt_q == '0) && (vCnt_q == '0);
    assign frame_cnt   = frameCnt_q;
    assign vga_h_sync  = hSync_q;
    assign vga_v_sync  = vSync_q;
    assign vga_R       = red_q;
    assign vga_G       = green_q;
    assign vga_B       = blue_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (!en) begin
            div_q <= '0;
        end else if (div_q == DW'(CLK_DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Soft stop clears the raster but keeps the completed-frame count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCnt_q     <= '0;
            vCnt_q     <= '0;
            frameCnt_q <= '0;
        end else if (!en) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else if (tick) begin
            if (hLast) begin
                hCnt_q <= '0;
                if (vLast) begin
                    vCnt_q     <= '0;
                    frameCnt_q <= frameCnt_q + 16'd1;
                end else begin
                    vCnt_q <= vCnt_q + YW'(1);
                end
            end else begin
                hCnt_q <= hCnt_q + XW'(1);
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_direct
            assign dlyOut = stage0;
        end else begin : g_delay
            logic [3*PIPE-1:0] dly_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dly_q <= '0;
                end else if (!en) begin
                    dly_q <= '0;
                end else if (tick) begin
                    for (int i = int'(PIPE) - 1; i > 0; i--) begin
                        dly_q[3*i +: 3] <= dly_q[3*(i-1) +: 3];
                    end
                    dly_q[2:0] <= stage0;
                end
            end

            assign dlyOut = dly_q[3*PIPE-1 -: 3];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hSync_q <= ~HS_POL;
            vSync_q <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (!en) begin
            hSync_q <= ~HS_POL;
            vSync_q <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (tick) begin
            hSync_q <= dlyOut[1] ? HS_POL : ~HS_POL;
            vSync_q <= dlyOut[0] ? VS_POL : ~VS_POL;
            red_q   <= dlyOut[2] ? pix_r : '0;
            green_q <= dlyOut[2] ? pix_g : '0;
            blue_q  <= dlyOut[2] ? pix_b : '0;
        end
    end

endmodule
